// File: rtl/hamming_pkg.sv
// Shared SECDED (16,11) definitions for the Hamming encoder and decoder.
// Combinational only: no clock, no latency, no flow control.
// Codeword is indexed [16:1]: parity at 1,2,4,8, overall parity at 16, data elsewhere.
package hamming_pkg;

    localparam int CODE_W = 16;
    localparam int DATA_W = 11;

    // Parity bit positions within the [16:1] codeword.
    localparam int P1_POS   = 1;
    localparam int P2_POS   = 2;
    localparam int P4_POS   = 4;
    localparam int P8_POS   = 8;
    localparam int PALL_POS = 16;

    // Codeword position of data bit D(i+1), i = 0..10.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic logic [CODE_W:1] hamming_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W:1] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c[DATA_POS[i]] = data[i];
        end
        // data[k] is D(k+1)
        c[P1_POS] = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10];
        c[P2_POS] = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[10];
        c[P4_POS] = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
        c[P8_POS] = data[4] ^ data[5] ^ data[6] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
        // Overall bit makes the full 16-bit word even parity.
        c[PALL_POS] = ^c[CODE_W-1:1];
        return c;
    endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Generic DEPTH x W synchronous FIFO with synchronous active-high reset.
// Latency: a pushed word is readable (empty_o=0) the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; flags are registered-state only.
// Ports: clk, rst; push_i/wdata_i write side; pop_i/rdata_o read side; full_o, empty_o status.
module hamming_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Head is forced to zero when empty so the read port has a defined reset value
    // without clearing the storage array.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Pointers wrap naturally since DEPTH is a power of two.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming SECDED encoder: 11-bit words in, 16-bit extended-Hamming codewords out via a FIFO.
// Latency: one cycle from input accept to out_valid when the FIFO is empty; one word/cycle throughput.
// Backpressure: in_ready = !full from registered occupancy only, never combinational on out_ready.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready upstream; out_code/out_valid/
// out_ready downstream; word_count = codewords handed off since reset (wraps silently).
// Option HAMMING_ERR_INJECT_EN: adds inj_mask (XORed into the codeword at accept) and
// inj_count (accepted words with a non-zero mask).
module hamming_encoder_stream
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [16:1]        out_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] word_count
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic [16:1]        inj_mask,
    output logic [COUNT_W-1:0] inj_count
`endif
);

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [CODE_W:1]   code_d;
    logic [COUNT_W-1:0] word_count_q, word_count_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef HAMMING_ERR_INJECT_EN
    logic [COUNT_W-1:0] inj_count_q, inj_count_d;

    assign code_d      = hamming_encode(in_data) ^ inj_mask;
    assign inj_count_d = (push && (inj_mask != '0)) ? inj_count_q + CNT_ONE : inj_count_q;
    assign inj_count   = inj_count_q;

    always_ff @(posedge clk) begin
        if (rst) inj_count_q <= '0;
        else     inj_count_q <= inj_count_d;
    end
`else
    assign code_d = hamming_encode(in_data);
`endif

    assign word_count_d = pop ? word_count_q + CNT_ONE : word_count_q;
    assign word_count   = word_count_q;

    always_ff @(posedge clk) begin
        if (rst) word_count_q <= '0;
        else     word_count_q <= word_count_d;
    end

    hamming_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (code_d),
        .pop_i   (pop),
        .rdata_o (out_code),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_hamming_encoder_stream.sv
module tb_hamming_encoder_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:1] out_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;
    logic [16:1] mask;
`ifdef HAMMING_ERR_INJECT_EN
    logic [15:0] inj_count;
`endif

    always #5 clk = ~clk;

    hamming_encoder_stream #(.FIFO_DEPTH(2), .COUNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_mask   (mask),
        .inj_count  (inj_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    bit syn_chk = 1'b1;
    logic [16:1] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built from the positional definition: data fills the
    // non-power-of-two slots in order, parity 2^b covers positions with bit b set.
    function automatic logic [16:1] enc(input logic [10:0] d);
        logic [16:1] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if (((p >> b) & 1) == 1 && (p & (p - 1)) != 0) par ^= c[p];
            end
            c[1 << b] = par;
        end
        c[16] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [3:0] syn(input logic [16:1] c);
        logic [3:0] s;
        logic [31:0] pv;
        s = '0;
        for (int p = 1; p <= 15; p++) begin
            pv = p;
            if (c[p]) s ^= pv[3:0];
        end
        return s;
    endfunction

    // Scoreboard: handshakes are observed on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_count = 0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(enc(in_data) ^ mask);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("sb_code", 32'(out_code), 32'(exp_q.pop_front()));
                    if (syn_chk) begin
                        check("sb_syndrome", 32'(syn(out_code)), 32'd0);
                        check("sb_parity", 32'(^out_code), 32'd0);
                    end
                end
                exp_count++;
            end
        end
    end

    typedef struct {
        logic [10:0] d;
        logic [16:1] code;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] w0, w1, w2, d;
        logic [31:0] r;
        logic [16:1] fixed;
        int stalls;
        int base;

        vec[0] = '{11'h000, 16'h0000};
        vec[1] = '{11'h7FF, 16'hFFFF};
        vec[2] = '{11'h001, 16'h8007};
        vec[3] = '{11'h002, 16'h8019};
        vec[4] = '{11'h400, 16'hC08B};
        vec[5] = '{11'h010, 16'h8181};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        rst = 1'b0;

        // Table: single words, one-cycle latency, exact codeword values.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_data = vec[i].d; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("tbl_latency_valid", 32'(out_valid), 32'd1);
            check("tbl_code", 32'(out_code), 32'(vec[i].code));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("tbl_word_count", 32'(word_count), 32'(i + 1));
            check("tbl_drained", 32'(out_valid), 32'd0);
        end

        // Backpressure: three words into a two-deep FIFO with the sink stalled.
        w0 = 11'h123; w1 = 11'h456; w2 = 11'h789;
        @(posedge clk); #1;
        in_data = w0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_one_in", 32'(in_ready), 32'd1);
        in_data = w1;
        @(posedge clk); #1;
        check("bp_full", 32'(in_ready), 32'd0);
        in_data = w2;
        @(posedge clk); #1;
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_code", 32'(out_code), 32'(enc(w0)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_free_after_pop", 32'(in_ready), 32'd1);
        check("bp_order1", 32'(out_code), 32'(enc(w1)));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_accepted", 32'(out_valid), 32'd1);
        check("bp_order2", 32'(out_code), 32'(enc(w2)));
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_word_count", 32'(word_count), 32'(NV + 3));

        // Streaming: 100 random words at full rate.
        base = NV + 3;
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            r = $urandom;
            in_data = r[10:0];
            in_valid = 1'b1;
            if (!in_ready) stalls++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int t = 0; t < 10 && out_valid; t++) begin
            @(posedge clk); #1;
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_word_count", 32'(word_count), 32'(base + 100));
        check("stream_model_count", 32'(word_count), 32'(exp_count));
        check("stream_drained", 32'(out_valid), 32'd0);

        // Reset with two words buffered: both must vanish.
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 11'h2AA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 11'h555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_buffered", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_word_count", 32'(word_count), 32'd0);
        check("mid_out_code", 32'(out_code), 32'd0);
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            check("mid_never_emitted", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

`ifdef HAMMING_ERR_INJECT_EN
        syn_chk = 1'b0;
        d = 11'h155;
        @(posedge clk); #1;
        in_data = d; mask = 16'h0010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mask = '0;
        check("inj_single_syndrome", 32'(syn(out_code)), 32'd5);
        check("inj_single_parity", 32'(^out_code), 32'd1);
        fixed = out_code;
        fixed[syn(out_code)] = ~fixed[syn(out_code)];
        check("inj_single_corrected", 32'(fixed), 32'(enc(d)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_data = d; mask = 16'h0011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mask = '0;
        check("inj_double_syndrome", 32'(syn(out_code)), 32'd4);
        check("inj_double_parity", 32'(^out_code), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("inj_count", 32'(inj_count), 32'd2);
        syn_chk = 1'b1;
`else
        d = '0;
        fixed = '0;
`endif

        @(posedge clk); #1;
        check("sb_all_drained", 32'(exp_q.size()), 32'd0);
        check("final_model_count", 32'(word_count), 32'(exp_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
